// File: rtl/systolic_output_writer.sv
// Output writer for the weight-stationary systolic matmul: captures skewed per-column
// results from bottom_out, rebuilds output rows and writes one row per cycle to RAM.
module systolic_output_writer #(
    parameter int          ROWS          = 4,
    parameter int          COLS          = 4,
    parameter int          WORD_SIZE     = 16,
    parameter logic [31:0] OUT_BASE_ADDR = 32'h0000_0200,
    parameter int          ADDR_INCR     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_fsm,
    input  logic                      stall,
    input  logic [COLS*WORD_SIZE-1:0] matmul_output,
    input  logic [COLS-1:0]           output_col_valid,
    input  logic                      fsm_done,
    output logic                      wr_output_rdy,
    output logic                      wr_output_done,
    output logic                      wr_mem_en,
    output logic [31:0]               wr_mem_addr,
    output logic [COLS*WORD_SIZE-1:0] wr_mem_data,
    output logic                      err_overrun,
    output logic                      err_underrun
);

    // state   | meaning
    // IDLE    | ready for a job, wr_output_rdy high
    // CAPTURE | collecting column samples, writing rows as they complete
    // DRAIN   | controller finished; flushing remaining rows
    // DONE    | one-cycle wr_output_done pulse
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

    localparam int              CW      = $clog2(ROWS) + 1;
    localparam logic [CW-1:0]   ROWS_C  = CW'(ROWS);
    localparam logic [31:0]     INCR_32 = 32'(ADDR_INCR);

    state_t                       state;
    state_t                       state_nxt;
    logic [WORD_SIZE-1:0]         row_buf [ROWS][COLS];
    logic [CW-1:0]                col_cnt [COLS];
    logic [CW-1:0]                wr_row;
    logic                         arm;
    logic                         active;
    logic                         row_ready;
    logic                         all_captured;
    logic [COLS*WORD_SIZE-1:0]    row_data;

    assign arm            = (state == IDLE) && start_fsm;
    assign active         = (state == CAPTURE) || (state == DRAIN);
    // After an underrun every remaining row is flushed, zeros standing in for lost samples.
    assign row_ready      = active && (wr_row < ROWS_C) &&
                            (err_underrun || (col_cnt[COLS-1] > wr_row));
    assign wr_output_rdy  = (state == IDLE);
    assign wr_output_done = (state == DONE);

    always_comb begin
        all_captured = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (col_cnt[c] < ROWS_C) all_captured = 1'b0;
        end
    end

    always_comb begin
        row_data = '0;
        for (int k = 0; k < ROWS; k++) begin
            if (wr_row == CW'(k)) begin
                for (int c = 0; c < COLS; c++) begin
                    row_data[c*WORD_SIZE +: WORD_SIZE] = row_buf[k][c];
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_fsm) state_nxt = CAPTURE;
            CAPTURE: if (fsm_done)  state_nxt = (wr_row == ROWS_C) ? DONE : DRAIN;
            DRAIN:   if (wr_row == ROWS_C) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ROWS; k++)
                for (int c = 0; c < COLS; c++) row_buf[k][c] <= '0;
            for (int c = 0; c < COLS; c++) col_cnt[c] <= '0;
            wr_row       <= '0;
            wr_mem_en    <= 1'b0;
            wr_mem_addr  <= '0;
            wr_mem_data  <= '0;
            err_overrun  <= 1'b0;
            err_underrun <= 1'b0;
        end else if (arm) begin
            for (int k = 0; k < ROWS; k++)
                for (int c = 0; c < COLS; c++) row_buf[k][c] <= '0;
            for (int c = 0; c < COLS; c++) col_cnt[c] <= '0;
            wr_row       <= '0;
            wr_mem_en    <= 1'b0;
            err_overrun  <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            wr_mem_en <= 1'b0;
            if (active && !stall) begin
                for (int c = 0; c < COLS; c++) begin
                    if (output_col_valid[c]) begin
                        if (col_cnt[c] < ROWS_C) begin
                            for (int k = 0; k < ROWS; k++) begin
                                if (col_cnt[c] == CW'(k))
                                    row_buf[k][c] <= matmul_output[c*WORD_SIZE +: WORD_SIZE];
                            end
                            col_cnt[c] <= col_cnt[c] + CW'(1);
                        end else begin
                            err_overrun <= 1'b1;
                        end
                    end
                end
            end
            if (row_ready) begin
                wr_mem_en   <= 1'b1;
                wr_mem_addr <= OUT_BASE_ADDR + 32'(wr_row) * INCR_32;
                wr_mem_data <= row_data;
                wr_row      <= wr_row + CW'(1);
            end
            if ((state == CAPTURE) && fsm_done && !all_captured) err_underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_systolic_output_writer.sv
// Self-checking bench for systolic_output_writer: table of jobs, random jobs, and a
// hand-written reset-during-write sequence, checked against a sample-list model.
`timescale 1ns/1ps
module tb_systolic_output_writer;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int W    = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                start_fsm = 1'b0;
    logic                stall = 1'b0;
    logic                fsm_done = 1'b0;
    logic [COLS*W-1:0]   matmul_output = '0;
    logic [COLS-1:0]     output_col_valid = '0;
    logic                wr_output_rdy, wr_output_done, wr_mem_en;
    logic                err_overrun, err_underrun;
    logic [31:0]         wr_mem_addr;
    logic [COLS*W-1:0]   wr_mem_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    systolic_output_writer dut (
        .clk(clk), .rst(rst), .start_fsm(start_fsm), .stall(stall),
        .matmul_output(matmul_output), .output_col_valid(output_col_valid),
        .fsm_done(fsm_done), .wr_output_rdy(wr_output_rdy),
        .wr_output_done(wr_output_done), .wr_mem_en(wr_mem_en),
        .wr_mem_addr(wr_mem_addr), .wr_mem_data(wr_mem_data),
        .err_overrun(err_overrun), .err_underrun(err_underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // write / done monitor
    logic [31:0]       wq_addr[$];
    logic [COLS*W-1:0] wq_data[$];
    int                wq_cyc[$];
    int                done_cyc[$];
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (wr_mem_en) begin
                wq_addr.push_back(wr_mem_addr);
                wq_data.push_back(wr_mem_data);
                wq_cyc.push_back(cyc);
            end
            if (wr_output_done) done_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        string          name;
        int             n_samp;
        logic [COLS-1:0] extra_mask;
        int             stall_mode;   // 0 none, 1 three stalls per beat, 2 random
        bit             rand_data;
        bit             chk_lat;
        bit             exp_over;
        bit             exp_under;
    } job_t;

    typedef struct {
        int          col;
        logic [W-1:0] d;
    } samp_t;

    function automatic logic [W-1:0] nominal_word(input int c, input int k);
        return W'((c << 12) | (k << 8) | k);
    endfunction

    task automatic wait_rdy(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (wr_output_rdy === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        chk({nm, "_rdy_wait"}, 64'(ok), 64'd1);
    endtask

    task automatic run_job(input job_t j);
        samp_t acc[$];
        int    cap3[$];
        int    n_c[COLS];
        int    nb;
        int    nst;
        bit    seen;
        logic [COLS*W-1:0] exp_row;
        int    cnt;

        wait_rdy(j.name);
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); done_cyc.delete();
        start_fsm = 1'b1;
        @(posedge clk); #1;
        start_fsm = 1'b0;

        nb = 0;
        for (int c = 0; c < COLS; c++) begin
            n_c[c] = j.n_samp + int'(j.extra_mask[c]);
            if (c + n_c[c] > nb) nb = c + n_c[c];
        end
        for (int t = 0; t < nb; t++) begin
            for (int c = 0; c < COLS; c++) begin
                output_col_valid[c] = (t >= c) && (t < c + n_c[c]);
                matmul_output[c*W +: W] = j.rand_data ? W'($urandom) : nominal_word(c, t - c);
            end
            nst = (j.stall_mode == 1) ? 3 : (j.stall_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int s = 0; s < nst; s++) begin
                stall = 1'b1;
                @(posedge clk); #1;
            end
            stall = 1'b0;
            @(posedge clk); #1;
            for (int c = 0; c < COLS; c++)
                if (output_col_valid[c]) acc.push_back('{c, matmul_output[c*W +: W]});
            if (output_col_valid[COLS-1]) cap3.push_back(cyc);
        end
        output_col_valid = '0;
        matmul_output    = '0;
        fsm_done         = 1'b1;

        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = wr_output_done;
        end
        chk({j.name, "_done_seen"}, 64'(seen), 64'd1);
        chk({j.name, "_overrun"},  64'(err_overrun),  64'(j.exp_over));
        chk({j.name, "_underrun"}, 64'(err_underrun), 64'(j.exp_under));
        fsm_done = 1'b0;
        @(negedge clk);
        chk({j.name, "_rdy_after"},  64'(wr_output_rdy),  64'd1);
        chk({j.name, "_done_width"}, 64'(wr_output_done), 64'd0);
        chk({j.name, "_done_pulses"}, 64'(done_cyc.size()), 64'd1);
        chk({j.name, "_write_count"}, 64'(wq_addr.size()), 64'(ROWS));

        for (int k = 0; k < ROWS && k < wq_addr.size(); k++) begin
            exp_row = '0;
            for (int c = 0; c < COLS; c++) begin
                cnt = 0;
                foreach (acc[i]) begin
                    if (acc[i].col == c) begin
                        if (cnt == k) exp_row[c*W +: W] = acc[i].d;
                        cnt++;
                    end
                end
            end
            chk($sformatf("%s_addr%0d", j.name, k), 64'(wq_addr[k]), 64'(32'h200 + 4 * k));
            chk($sformatf("%s_data%0d", j.name, k), wq_data[k], exp_row);
        end

        if (j.chk_lat && wq_cyc.size() == ROWS && cap3.size() >= ROWS) begin
            for (int k = 0; k < ROWS; k++)
                chk($sformatf("%s_wr_lat%0d", j.name, k), 64'(wq_cyc[k]), 64'(cap3[k] + 1));
            if (done_cyc.size() > 0)
                chk({j.name, "_done_lat"}, 64'(done_cyc[0]), 64'(wq_cyc[ROWS-1] + 1));
        end
    endtask

    job_t tbl[5];
    job_t rj;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{"nominal",   4, 4'b0000, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{"stall",     4, 4'b0000, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{"overrun",   4, 4'b0001, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{"underrun",  2, 4'b0000, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{"rnd_stall", 4, 4'b0000, 2, 1'b1, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        #1;
        chk("rst_rdy",   64'(wr_output_rdy),  64'd1);
        chk("rst_done",  64'(wr_output_done), 64'd0);
        chk("rst_en",    64'(wr_mem_en),      64'd0);
        chk("rst_addr",  64'(wr_mem_addr),    64'd0);
        chk("rst_data",  wr_mem_data,         64'd0);
        chk("rst_over",  64'(err_overrun),    64'd0);
        chk("rst_under", 64'(err_underrun),   64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_job(tbl[i]);

        for (int r = 0; r < 3; r++) begin
            rj = '{"random", 4, 4'($urandom_range(0, 15)), 2, 1'b1, 1'b0, 1'b0, 1'b0};
            rj.exp_over = |rj.extra_mask;
            run_job(rj);
        end

        // reset while rows are being written
        wait_rdy("midrst");
        start_fsm = 1'b1;
        @(posedge clk); #1;
        start_fsm = 1'b0;
        for (int t = 0; t < 6; t++) begin
            for (int c = 0; c < COLS; c++) begin
                output_col_valid[c] = (t >= c) && (t < c + ROWS);
                matmul_output[c*W +: W] = nominal_word(c, t - c);
            end
            @(posedge clk); #1;
        end
        chk("midrst_en_before", 64'(wr_mem_en), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_en",    64'(wr_mem_en),     64'd0);
        chk("midrst_rdy",   64'(wr_output_rdy), 64'd1);
        chk("midrst_addr",  64'(wr_mem_addr),   64'd0);
        chk("midrst_over",  64'(err_overrun),   64'd0);
        output_col_valid = '0;
        matmul_output    = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_job(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
